// File: rtl/pipeline_trace_pkg.sv
// rtl/pipeline_trace_pkg.sv - shared state encodings and trace record layout
package pipeline_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int TRACE_REC_W    = 65;
  localparam int REC_BRANCH_BIT = 0;
  localparam int REC_ALU_LSB    = 1;
  localparam int REC_PC_LSB     = 33;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [TRACE_REC_W-1:0] pack_rec(input logic [31:0] pc,
                                                      input logic [31:0] alu,
                                                      input logic        br);
    return {pc, alu, br};
  endfunction

endpackage

// File: rtl/pipeline_trace_capture_fifo.sv
// rtl/pipeline_trace_capture_fifo.sv - first-word-fall-through record FIFO with optional drop-oldest
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 65
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   drop_oldest,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO either evicts the head (drop_oldest) or rides on a real pop.
  assign do_pop  = (pop && !empty) || (drop_oldest && push && full);
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pipeline_trace_capture.sv
// rtl/pipeline_trace_capture.sv - armed PC-triggered execution trace capture
// TRACE_WRAP_EN selects circular capture; otherwise capture stops when the FIFO fills.
import pipeline_trace_pkg::*;

module pipeline_trace_capture #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] TRIG_PC = 32'h0000_0000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   arm,
  input  logic [31:0]            PCAddress,
  input  logic [31:0]            nextPCAddress,
  input  logic [31:0]            EX_ALUResult,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_alu,
  output logic                   rd_branch,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  trace_state_t           st_q, st_d;
  logic [31:0]            prev_pc;
  logic [TRACE_REC_W-1:0] rec_q;
  logic [TRACE_REC_W-1:0] head;
  logic                   push_q, push_d;
  logic                   fifo_full, fifo_empty;
  logic                   pop, reject, drop_en, branch;

  assign branch = (nextPCAddress != (PCAddress + PC_STEP));
  assign pop    = rd_valid && rd_ready;
  // Staged record arriving at a full FIFO with no pop to make room.
  assign reject = push_q && fifo_full && !pop;

`ifdef TRACE_WRAP_EN
  assign drop_en = 1'b1;
`else
  assign drop_en = 1'b0;
`endif

  always_comb begin
    st_d   = st_q;
    push_d = 1'b0;
    case (st_q)
      ST_IDLE: if (arm) st_d = ST_ARMED;
      ST_ARMED: begin
        if (!arm) st_d = ST_IDLE;
        else if (PCAddress == TRIG_PC) begin
          st_d   = ST_CAPTURE;
          push_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!arm) st_d = ST_IDLE;
`ifndef TRACE_WRAP_EN
        else if (reject) st_d = ST_DONE;
`endif
        else push_d = (PCAddress != prev_pc);
      end
      ST_DONE: if (!arm) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st_q     <= ST_IDLE;
      prev_pc  <= '0;
      rec_q    <= '0;
      push_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      st_q    <= st_d;
      prev_pc <= PCAddress;
      push_q  <= push_d;
      if (push_d) rec_q <= pack_rec(PCAddress, EX_ALUResult, branch);
      if (reject) overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH(DEPTH),
    .W    (TRACE_REC_W)
  ) u_fifo (
    .clk        (Clk),
    .resetn     (Reset),
    .push       (push_q),
    .pop        (pop),
    .drop_oldest(drop_en),
    .wdata      (rec_q),
    .rdata      (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count)
  );

  assign rd_valid  = !fifo_empty;
  assign rd_pc     = head[REC_PC_LSB +: 32];
  assign rd_alu    = head[REC_ALU_LSB +: 32];
  assign rd_branch = head[REC_BRANCH_BIT];
  assign state     = st_q;

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// tb/tb_pipeline_trace_capture.sv - self-checking bench for pipeline_trace_capture
module tb_pipeline_trace_capture;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] TRIG  = 32'h8;
`ifdef TRACE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          arm = 1'b0;
  logic          rd_ready = 1'b0;
  logic [31:0]   PCAddress = '0;
  logic [31:0]   nextPCAddress = '0;
  logic [31:0]   EX_ALUResult = '0;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_alu;
  logic          rd_branch;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          overflow;

  pipeline_trace_capture #(.DEPTH(DEPTH), .TRIG_PC(TRIG)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .arm          (arm),
    .PCAddress    (PCAddress),
    .nextPCAddress(nextPCAddress),
    .EX_ALUResult (EX_ALUResult),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_alu       (rd_alu),
    .rd_branch    (rd_branch),
    .state        (state),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic        br;
  } rec_t;

  // Reference model: queue of records, one-cycle staging, spec-level state rules.
  rec_t        q[$];
  int          m_st;
  logic [31:0] m_prev;
  bit          m_pend;
  rec_t        m_rec;
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit   full, pop, rej;
    rec_t s;
    if (!Reset) begin
      q.delete();
      m_st = 0; m_prev = '0; m_pend = 0; m_ovf = 0;
      return;
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && rd_ready;
    rej  = m_pend && full && !pop;
    if (pop) void'(q.pop_front());
    if (m_pend) begin
      if (!rej) q.push_back(m_rec);
      else begin
        m_ovf = 1;
        if (WRAP) begin
          void'(q.pop_front());
          q.push_back(m_rec);
        end
      end
    end
    s.pc  = PCAddress;
    s.alu = EX_ALUResult;
    s.br  = (nextPCAddress != PCAddress + 32'd4);
    m_pend = 0;
    if (m_st == 0) begin
      if (arm) m_st = 1;
    end else if (!arm) begin
      m_st = 0;
    end else if (m_st == 1) begin
      if (PCAddress == TRIG) begin m_st = 2; m_pend = 1; end
    end else if (m_st == 2) begin
      if (rej && !WRAP) m_st = 3;
      else m_pend = (PCAddress != m_prev);
    end
    if (m_pend) m_rec = s;
    m_prev = PCAddress;
  endtask

  task automatic compare_all();
    rec_t h;
    h = (q.size() > 0) ? q[0] : '0;
    check("state", 32'(state), 32'(m_st));
    check("count", 32'(count), 32'(q.size()));
    check("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
    check("rd_pc", rd_pc, h.pc);
    check("rd_alu", rd_alu, h.alu);
    check("rd_branch", 32'(rd_branch), 32'(h.br));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input bit a, input logic [31:0] pc, input logic [31:0] npc,
                      input bit rdy, input bit rst_n);
    arm = a; PCAddress = pc; nextPCAddress = npc;
    EX_ALUResult = $urandom(); rd_ready = rdy; Reset = rst_n;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic seq(input bit a, input logic [31:0] pc, input bit rdy);
    step(a, pc, pc + 32'd4, rdy, 1'b1);
  endtask

  typedef struct {
    bit          a;
    logic [31:0] pc;
    int          st;
    int          cnt;
    bit          v;
    logic [31:0] head;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] cur_pc;

  initial begin
    tbl[0] = '{1'b1, 32'h00, 1, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h04, 1, 0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h08, 2, 0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h0C, 2, 1, 1'b1, 32'h8};
    tbl[4] = '{1'b1, 32'h10, 2, 2, 1'b1, 32'h8};
    tbl[5] = '{1'b1, 32'h10, 2, 3, 1'b1, 32'h8};

    for (int i = 0; i < 2; i++) step($urandom(), $urandom(), $urandom(), $urandom(), 1'b0);
    check("reset_state", 32'(state), 32'd0);
    check("reset_valid", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      seq(tbl[i].a, tbl[i].pc, 1'b0);
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d_head", i), rd_pc, tbl[i].head);
    end
    check("trig_branch", 32'(rd_branch), 32'd0);
    for (int i = 0; i < 3; i++) seq(1'b1, 32'h10, 1'b1);
    check("drain_count", 32'(count), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b1, 32'h14, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) seq(1'b1, 32'h40, 1'b0);
    check("stall_count", 32'(count), 32'd2);
    check("stall_head", rd_pc, 32'h14);
    check("stall_branch", 32'(rd_branch), 32'd1);
    seq(1'b1, 32'h40, 1'b1);
    check("branch_next_pc", rd_pc, 32'h40);
    check("branch_next_br", 32'(rd_branch), 32'd0);
    seq(1'b1, 32'h40, 1'b1);

    for (int i = 0; i < 5; i++) seq(1'b1, 32'h100 + 32'(4 * i), 1'b0);
    check("full_count", 32'(count), 32'd4);
    seq(1'b1, 32'h110, 1'b1);
    check("pushpop_count", 32'(count), 32'd4);
    check("pushpop_ovf", 32'(overflow), 32'd0);
    check("pushpop_head", rd_pc, 32'h104);

    seq(1'b1, 32'h114, 1'b0);
    seq(1'b1, 32'h118, 1'b0);
    seq(1'b1, 32'h118, 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_state", 32'(state), WRAP ? 32'd2 : 32'd3);
    check("ovf_head", rd_pc, WRAP ? 32'h10C : 32'h104);

    seq(1'b0, 32'h118, 1'b0);
    check("disarm_state", 32'(state), 32'd0);
    check("disarm_count", 32'(count), 32'd4);
    check("disarm_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 4; i++) seq(1'b0, 32'h118, 1'b1);
    seq(1'b1, 32'h0, 1'b0);
    seq(1'b1, 32'h8, 1'b0);
    seq(1'b1, 32'hC, 1'b0);
    seq(1'b1, 32'h10, 1'b0);
    check("rearm_count", 32'(count), 32'd2);
    step(1'b1, 32'h14, 32'h18, 1'b0, 1'b0);
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_valid", 32'(rd_valid), 32'd0);
    check("midreset_state", 32'(state), 32'd0);

    cur_pc = '0;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       cur_pc = cur_pc + 32'd4;
      else if (r == 6) cur_pc = TRIG;
      else if (r == 7) cur_pc = $urandom() & 32'hFFFF_FFFC;
      else if (r == 8) cur_pc = 32'h0;
      else if (r == 9) cur_pc = 32'hFFFF_FFFC;
      step($urandom_range(0, 19) != 0, cur_pc,
           ($urandom_range(0, 3) == 0) ? $urandom() : cur_pc + 32'd4,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_capture.md
# pipeline_trace_capture

Synthesizable trace capture unit at the observation end of `PipelineCPU`. It samples `PCAddress`, `nextPCAddress` and `EX_ALUResult` every cycle. It arms on request and triggers on a programmed PC. Each newly fetched instruction is logged into an internal FIFO, which a host drains through a valid/ready read port. It replaces waveform inspection with a checkable, in-order execution trace for simulation and FPGA bring-up.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `TRIG_PC`, 32'h0000_0000, PC value that starts capture
- `Clk`  in  1  clock; all logic on rising edge
- `Reset`  in  1  synchronous, active-low reset
- `arm`  in  1  level; 1 = arm/keep capturing, 0 = stop and return to IDLE
- `PCAddress`  in  32  current PC from the CPU
- `nextPCAddress`  in  32  next PC from the CPU
- `EX_ALUResult`  in  32  EX-stage ALU result from the CPU
- `rd_valid`  out  1  head record available
- `rd_ready`  in  1  host accepts head record
- `rd_pc`  out  32  head record PC
- `rd_alu`  out  32  head record ALU result
- `rd_branch`  out  1  head record non-sequential flag
- `state`  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- `count`  out  $clog2(DEPTH)+1  records currently held
- `overflow`  out  1  sticky; a record was lost or overwritten

## Operation
- Record = {PC, ALU, branch}. `branch` is set when `nextPCAddress != PCAddress + 32'd4`, computed modulo 2^32 (so 32'hFFFF_FFFC→0 is sequential).
- New-instruction detect: a record is generated only when `PCAddress` differs from the PC sampled on the previous cycle. Stalls repeating the same PC produce no records. The first cycle in CAPTURE always generates a record.
- IDLE→ARMED: `arm`=1.
- ARMED→CAPTURE: `PCAddress == TRIG_PC`. That cycle's sample is recorded.
- ARMED/CAPTURE→IDLE: `arm`=0. FIFO contents are retained.
- CAPTURE→DONE: only without `TRACE_WRAP_EN` (see Configuration).
- DONE→IDLE: `arm`=0.
- IDLE and DONE never write.
- Reads are legal in every state. A pop occurs on `rd_valid && rd_ready`.
- Simultaneous push and pop: both take effect and `count` is unchanged. This also applies when the FIFO is full, in which case no overflow occurs.
- Pop on empty: ignored, because `rd_valid`=0.
- `overflow` clears only on reset.

## Timing
- Reset (Reset=0 at a rising edge): `state`=IDLE, FIFO empty, `count`=0, `rd_valid`=0, `rd_pc`=0, `rd_alu`=0, `rd_branch`=0, `overflow`=0, previous-PC register=0.
- Reset mid-capture discards all records. It takes priority over every other event in the same cycle.
- Push latency: a record sampled at edge N is visible at the head (if the FIFO was empty) with `rd_valid`=1 after edge N+1.
- Read port is first-word-fall-through: `rd_pc`/`rd_alu`/`rd_branch` are stable while `rd_valid`=1 and no pop occurs. After a pop, the next head appears the following cycle.
- `count` and `state` are registered outputs that reflect the effect of the previous edge.
- The trigger compare and the transition to CAPTURE take effect at the same edge as the first push.

## Configuration
- `TRACE_WRAP_EN` defined: circular mode. A push into a full FIFO without a simultaneous pop drops the oldest record (read pointer advances), writes the new one, and sets `overflow`. `state` stays CAPTURE. `count` stays DEPTH.
- `TRACE_WRAP_EN` undefined: stop-on-full mode. A push into a full FIFO without a pop discards the new record, sets `overflow`, and moves CAPTURE→DONE. DONE never rearms until `arm`=0 then 1.

## Structure
- Shared package `pipeline_trace_pkg` holds:
  - state encodings `ST_IDLE`/`ST_ARMED`/`ST_CAPTURE`/`ST_DONE`
  - record width constant `TRACE_REC_W` = 65
  - field offsets for PC, ALU and branch
  - `PC_STEP` = 32'd4
- Sub-module `trace_fifo`:
  - parameterized DEPTH × `TRACE_REC_W` synchronous FIFO
  - FWFT read, push/pop/full/empty/count
  - a `drop_oldest` input used only under `TRACE_WRAP_EN`
- The top holds the FSM, new-PC detect, branch compute and overflow flag.

## Test plan
- Reset check: hold Reset=0 for 2 cycles with random inputs → all outputs 0, `state`=0.
- Trigger: TRIG_PC=32'h8, arm=1, PC sequence 0,4,8,C,10 → `state` goes 1→2 at the edge sampling PC=8. The FIFO then holds PCs 8,C,10 in order, `count`=3, `rd_branch`=0.
- Stall/branch: in CAPTURE, PC=14 held 3 cycles with nextPC=40, then PC=40 → exactly two records: {14, branch=1} and {40}.
- Full, no wrap: DEPTH=4, rd_ready=0, 6 distinct PCs → `count`=4, `overflow`=1, `state`=3, FIFO holds the first 4. With wrap: FIFO holds the last 4, `state`=2.
- Full with simultaneous pop: FIFO full, rd_ready=1 while a new PC arrives → `count` stays 4, `overflow` stays 0, head advances.
- Disarm and reset mid-capture: arm=0 → `state`=0 with records kept and readable. Re-arm, capture 2 records, then Reset=0 → `count`=0, `rd_valid`=0 next cycle.
